// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - Program-counter sequencer with return-stack push/pop control
// Traps stack overflow/underflow locally so a bad call/ret never reaches the stack.
module pc_sequencer #(
  parameter int                 WIDTH      = 10,
  parameter int                 DEPTH      = 16,
  parameter logic [WIDTH-1:0]   RESET_PC   = '0,
  parameter logic [WIDTH-1:0]   IRQ_VECTOR = 10'h3F0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       jump,
  input  logic                       cond_jump,
  input  logic                       zero,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       halt,
  input  logic [WIDTH-1:0]           target,
  input  logic                       irq,
  input  logic [WIDTH-1:0]           stack_top,
  output logic [WIDTH-1:0]           pc,
  output logic                       push,
  output logic                       pop,
  output logic [WIDTH-1:0]           ret_addr,
  output logic                       kill,
  output logic                       irq_ack,
  output logic                       in_isr,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       fault,
  output logic                       halted
);

  localparam int DW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [DW-1:0]    r_depth, w_depth_nxt;
  logic             r_isr, w_isr_nxt;
  logic             r_fault, r_halted;
  logic             w_full, w_empty, w_irq_take, w_fault_evt;

  assign w_pc_inc   = r_pc + WIDTH'(1);
  assign w_full     = (r_depth == DW'(DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_irq_take = irq && !r_isr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_depth  <= '0;
      r_isr    <= 1'b0;
      r_fault  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_depth  <= w_depth_nxt;
      r_isr    <= w_isr_nxt;
      r_fault  <= (w_state_nxt == ST_FAULT);
      r_halted <= (w_state_nxt == ST_HALT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_isr_nxt   = r_isr;
    w_fault_evt = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    ret_addr    = '0;
    kill        = 1'b0;
    irq_ack     = 1'b0;

    if (r_state != ST_RUN && r_state != ST_HALT) begin
      kill        = 1'b1;
      w_state_nxt = ST_FAULT;
    end else if (w_irq_take) begin
      // The interrupted instruction is killed and re-executes on return.
      if (w_full) begin
        w_fault_evt = 1'b1;
      end else begin
        push        = 1'b1;
        ret_addr    = r_pc;
        kill        = 1'b1;
        irq_ack     = 1'b1;
        w_pc_nxt    = IRQ_VECTOR;
        w_isr_nxt   = 1'b1;
        w_depth_nxt = r_depth + DW'(1);
        w_state_nxt = ST_RUN;
      end
    end else if (r_state == ST_RUN) begin
      if (ret) begin
        if (w_empty) begin
          w_fault_evt = 1'b1;
        end else begin
          pop         = 1'b1;
          w_pc_nxt    = stack_top;
          w_depth_nxt = r_depth - DW'(1);
          w_isr_nxt   = 1'b0;
        end
      end else if (call) begin
        if (w_full) begin
          w_fault_evt = 1'b1;
        end else begin
          push        = 1'b1;
          ret_addr    = w_pc_inc;
          w_pc_nxt    = target;
          w_depth_nxt = r_depth + DW'(1);
        end
      end else if (jump) begin
        w_pc_nxt = target;
      end else if (cond_jump) begin
        w_pc_nxt = zero ? target : w_pc_inc;
      end else if (halt) begin
        w_state_nxt = ST_HALT;
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end

    if (w_fault_evt) begin
      push        = 1'b0;
      pop         = 1'b0;
      ret_addr    = '0;
      irq_ack     = 1'b0;
      kill        = 1'b1;
      w_pc_nxt    = r_pc;
      w_depth_nxt = r_depth;
      w_isr_nxt   = r_isr;
      w_state_nxt = ST_FAULT;
    end

    // Registers are already cleared asynchronously; keep the stack untouched too.
    if (reset) begin
      push     = 1'b0;
      pop      = 1'b0;
      ret_addr = '0;
      kill     = 1'b0;
      irq_ack  = 1'b0;
    end
  end

  assign pc     = r_pc;
  assign depth  = r_depth;
  assign in_isr = r_isr;
  assign fault  = r_fault;
  assign halted = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - Self-checking bench for pc_sequencer
// Directed scenarios plus randomized cycles against a queue-based reference model.
module tb_pc_sequencer;

  localparam int         W    = 10;
  localparam int         D    = 16;
  localparam logic [9:0] IRQV = 10'h3F0;

  logic       clk = 1'b0;
  logic       reset;
  logic       jump, cond_jump, zero, call, ret, halt, irq;
  logic [9:0] target, stack_top;
  logic [9:0] pc, ret_addr;
  logic       push, pop, kill, irq_ack, in_isr, fault, halted;
  logic [4:0] depth;

  int errors = 0;
  int checks = 0;

  logic [9:0] m_pc;
  logic [9:0] m_stk[$];
  bit         m_isr, m_halt, m_fault;
  bit         e_push, e_pop, e_kill, e_ack;
  logic [9:0] e_ra;

  pc_sequencer #(.WIDTH(W), .DEPTH(D), .RESET_PC(10'h000), .IRQ_VECTOR(IRQV)) dut (
    .clk(clk), .reset(reset), .jump(jump), .cond_jump(cond_jump), .zero(zero),
    .call(call), .ret(ret), .halt(halt), .target(target), .irq(irq),
    .stack_top(stack_top), .pc(pc), .push(push), .pop(pop), .ret_addr(ret_addr),
    .kill(kill), .irq_ack(irq_ack), .in_isr(in_isr), .depth(depth),
    .fault(fault), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic j, input logic cj, input logic z, input logic c,
                        input logic r, input logic h, input logic [9:0] t, input logic i);
    jump = j; cond_jump = cj; zero = z; call = c; ret = r; halt = h; target = t; irq = i;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0, 10'h000, 0);
    stack_top = 10'h000;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 10'h000; m_stk.delete(); m_isr = 0; m_halt = 0; m_fault = 0;
  endtask

  // Applies one cycle of the sequencing rules to the model and records expected strobes.
  task automatic model_step();
    bit flt;
    flt = 0;
    e_push = 0; e_pop = 0; e_kill = 0; e_ack = 0; e_ra = 10'h000;
    if (m_fault) begin
      e_kill = 1;
    end else if (irq && !m_isr) begin
      if (m_stk.size() == D) flt = 1;
      else begin
        e_push = 1; e_ra = m_pc; e_kill = 1; e_ack = 1;
        m_stk.push_back(m_pc); m_pc = IRQV; m_isr = 1; m_halt = 0;
      end
    end else if (!m_halt) begin
      if (ret) begin
        if (m_stk.size() == 0) flt = 1;
        else begin e_pop = 1; m_pc = m_stk.pop_back(); m_isr = 0; end
      end else if (call) begin
        if (m_stk.size() == D) flt = 1;
        else begin
          e_push = 1; e_ra = m_pc + 10'd1;
          m_stk.push_back(m_pc + 10'd1); m_pc = target;
        end
      end else if (jump) m_pc = target;
      else if (cond_jump) m_pc = zero ? target : m_pc + 10'd1;
      else if (halt) m_halt = 1;
      else m_pc = m_pc + 10'd1;
    end
    if (flt) begin e_kill = 1; m_fault = 1; m_halt = 0; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 1, 0, 0, 10'h055, 1);
    #3;
    checks++; if (push !== 1'b0) begin errors++; $display("FAIL reset_push got=%b exp=0", push); end
    checks++; if (kill !== 1'b0) begin errors++; $display("FAIL reset_kill got=%b exp=0", kill); end
    do_reset();
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", pc); end
    checks++; if (depth !== 5'd0) begin errors++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    checks++; if ({fault, halted, in_isr} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {fault, halted, in_isr}); end
  endtask

  task automatic test_increment();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      #3;
      checks++; if ({push, pop} !== 2'b00) begin errors++; $display("FAIL inc_strobes got=%b exp=00", {push, pop}); end
      tick();
      checks++; if (pc !== 10'(k)) begin errors++; $display("FAIL inc_pc got=%h exp=%h", pc, 10'(k)); end
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    repeat (5) tick();
    set_in(0, 0, 0, 1, 0, 0, 10'h040, 0);
    #3;
    checks++; if (push !== 1'b1 || ret_addr !== 10'h006) begin errors++; $display("FAIL call_push got=%b/%h exp=1/006", push, ret_addr); end
    tick();
    checks++; if (pc !== 10'h040 || depth !== 5'd1) begin errors++; $display("FAIL call_pc got=%h/%0d exp=040/1", pc, depth); end
    set_in(0, 0, 0, 0, 1, 0, 10'h000, 0);
    stack_top = 10'h006;
    #3;
    checks++; if (pop !== 1'b1 || push !== 1'b0) begin errors++; $display("FAIL ret_pop got=%b%b exp=10", pop, push); end
    tick();
    checks++; if (pc !== 10'h006 || depth !== 5'd0) begin errors++; $display("FAIL ret_pc got=%h/%0d exp=006/0", pc, depth); end
    idle_in();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      set_in(0, 0, 0, 1, 0, 0, 10'h100 + 10'(k), 0);
      tick();
    end
    checks++; if (depth !== 5'd16 || pc !== 10'h10F) begin errors++; $display("FAIL ovf_fill got=%0d/%h exp=16/10f", depth, pc); end
    set_in(0, 0, 0, 1, 0, 0, 10'h2AA, 0);
    #3;
    checks++; if (push !== 1'b0 || kill !== 1'b1) begin errors++; $display("FAIL ovf_strobe got=push%b kill%b exp=push0 kill1", push, kill); end
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(1, 0, 0, 0, 0, 0, 10'h0AA, 1);
      #3;
      checks++; if (pc !== 10'h10F || fault !== 1'b1 || kill !== 1'b1 || push !== 1'b0) begin
        errors++; $display("FAIL ovf_frozen got=pc%h f%b k%b p%b exp=pc10f f1 k1 p0", pc, fault, kill, push); end
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (pc !== 10'h000 || fault !== 1'b0 || depth !== 5'd0 || push !== 1'b0) begin
      errors++; $display("FAIL async_reset got=pc%h f%b d%0d p%b exp=pc000 f0 d0 p0", pc, fault, depth, push); end
    do_reset();
  endtask

  task automatic test_underflow();
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 10'h000, 0);
    stack_top = 10'h123;
    #3;
    checks++; if (pop !== 1'b0 || kill !== 1'b1) begin errors++; $display("FAIL unf_strobe got=pop%b kill%b exp=pop0 kill1", pop, kill); end
    tick();
    checks++; if (fault !== 1'b1 || pc !== 10'h000) begin errors++; $display("FAIL unf_fault got=f%b pc%h exp=f1 pc000", fault, pc); end
    idle_in();
  endtask

  task automatic test_irq();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 10'h012, 0);
    tick();
    set_in(1, 0, 0, 0, 0, 0, 10'h055, 1);
    #3;
    checks++; if ({push, irq_ack, kill} !== 3'b111 || ret_addr !== 10'h012) begin
      errors++; $display("FAIL irq_take got=pak%b ra%h exp=pak111 ra012", {push, irq_ack, kill}, ret_addr); end
    tick();
    checks++; if (pc !== IRQV || in_isr !== 1'b1 || depth !== 5'd1) begin errors++; $display("FAIL irq_vec got=%h/%b/%0d exp=3f0/1/1", pc, in_isr, depth); end
    set_in(0, 0, 0, 0, 0, 0, 10'h000, 1);
    #3;
    checks++; if (irq_ack !== 1'b0 || push !== 1'b0) begin errors++; $display("FAIL irq_nested got=ack%b p%b exp=ack0 p0", irq_ack, push); end
    tick();
    checks++; if (pc !== 10'h3F1) begin errors++; $display("FAIL irq_isr_inc got=%h exp=3f1", pc); end
    set_in(0, 0, 0, 0, 1, 0, 10'h000, 0);
    stack_top = 10'h012;
    tick();
    checks++; if (pc !== 10'h012 || in_isr !== 1'b0 || depth !== 5'd0) begin errors++; $display("FAIL irq_return got=%h/%b/%0d exp=012/0/0", pc, in_isr, depth); end
    idle_in();
  endtask

  task automatic test_halt();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 10'h007, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 1, 10'h000, 0);
    tick();
    checks++; if (pc !== 10'h007 || halted !== 1'b1) begin errors++; $display("FAIL halt_enter got=%h/%b exp=007/1", pc, halted); end
    set_in(1, 0, 0, 1, 0, 0, 10'h020, 0);
    tick();
    checks++; if (pc !== 10'h007 || halted !== 1'b1 || depth !== 5'd0) begin errors++; $display("FAIL halt_ignore got=%h/%b/%0d exp=007/1/0", pc, halted, depth); end
    set_in(0, 0, 0, 0, 0, 0, 10'h000, 1);
    #3;
    checks++; if (push !== 1'b1 || ret_addr !== 10'h007) begin errors++; $display("FAIL halt_irq got=%b/%h exp=1/007", push, ret_addr); end
    tick();
    checks++; if (pc !== IRQV || halted !== 1'b0) begin errors++; $display("FAIL halt_wake got=%h/%b exp=3f0/0", pc, halted); end
    idle_in();
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 10'h3FF, 0);
    tick();
    set_in(0, 1, 0, 0, 0, 0, 10'h155, 0);
    tick();
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL wrap_cond got=%h exp=000", pc); end
    set_in(1, 0, 0, 0, 0, 0, 10'h3FF, 0);
    tick();
    set_in(0, 0, 0, 1, 0, 0, 10'h033, 0);
    #3;
    checks++; if (push !== 1'b1 || ret_addr !== 10'h000) begin errors++; $display("FAIL wrap_call got=%b/%h exp=1/000", push, ret_addr); end
    tick();
    idle_in();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (m_fault && $urandom_range(0, 3) == 0) begin
        do_reset();
        model_reset();
      end
      r = $urandom_range(0, 99);
      set_in(r < 10, r >= 10 && r < 20, 1'($urandom), r >= 20 && r < 42,
             r >= 42 && r < 62, r >= 62 && r < 67, 10'($urandom), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) begin jump = 1; call = 1; end
      stack_top = (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 10'($urandom);
      model_step();
      #3;
      checks++; if ({push, pop, kill, irq_ack} !== {e_push, e_pop, e_kill, e_ack}) begin
        errors++; $display("FAIL rnd_strobes cyc=%0d got=%b exp=%b", cyc, {push, pop, kill, irq_ack}, {e_push, e_pop, e_kill, e_ack}); end
      checks++; if (ret_addr !== e_ra) begin errors++; $display("FAIL rnd_ret_addr cyc=%0d got=%h exp=%h", cyc, ret_addr, e_ra); end
      tick();
      checks++; if (pc !== m_pc || depth !== 5'(m_stk.size())) begin
        errors++; $display("FAIL rnd_pc_depth cyc=%0d got=%h/%0d exp=%h/%0d", cyc, pc, depth, m_pc, m_stk.size()); end
      checks++; if ({in_isr, fault, halted} !== {m_isr, m_fault, m_halt}) begin
        errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc, {in_isr, fault, halted}, {m_isr, m_fault, m_halt}); end
    end
    idle_in();
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    test_reset();
    test_increment();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_irq();
    test_halt();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
